i2c_bus_arbiter: RTL and testbench

Shares the single byte-level I2C engine (start/RW/opcode in; busy/tick_done/16-bit data out) between two requesters. Requester 0 is the BH1750 light-sensor sequencer. Requester 1 is the LCD1602 I2C-backpack writer.
Each grant covers exactly one complete engine transaction, followed by a bus turnaround gap. Grants alternate round-robin when both requesters are waiting. A watchdog aborts transactions that hang.

---
 rtl/i2c_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one byte-level I2C engine between the BH1750
// sequencer (requester 0) and the LCD1602 backpack writer (requester 1).
module i2c_bus_arbiter #(
   parameter int TIMEOUT_CYCLES = 25_000_000,
   parameter int GAP_CYCLES     = 250,
   parameter int CNT_W          = 32
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [1:0]  i_req,
   input  logic [1:0]  i_rw,
   input  logic [15:0] i_opcode,
   output logic [1:0]  o_gnt,
   output logic [1:0]  o_done,
   output logic        o_err,
   output logic [15:0] o_rdata,
   output logic        o_eng_start,
   output logic        o_eng_rw,
   output logic [7:0]  o_eng_opcode,
   input  logic        i_eng_busy,
   input  logic        i_eng_tick_done,
   input  logic [15:0] i_eng_data
);

   typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE, S_GAP} state_t;

   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             g, g_nxt, ptr, ptr_nxt;
   logic             win, any_req, tmo, fin_ok, fin_to;
   logic [1:0]       gnt_nxt, done_nxt;
   logic             err_nxt, start_nxt, rw_nxt;
   logic [15:0]      rdata_nxt;
   logic [7:0]       op_nxt;

   assign any_req = |i_req;
   // Contention goes to ptr; a lone requester wins outright.
   assign win     = (&i_req) ? ptr : i_req[1];
   assign tmo     = (cnt == TO_LAST);
   // tick_done beats a coincident timeout.
   assign fin_ok  = (state == S_WAIT) && i_eng_tick_done;
   assign fin_to  = ((state == S_LAUNCH) || (state == S_WAIT)) && tmo && !fin_ok;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (any_req) state_nxt = S_LAUNCH;
         S_LAUNCH: if (fin_to) state_nxt = S_DONE;
                   else if (i_eng_busy) state_nxt = S_WAIT;
         S_WAIT:   if (fin_ok || fin_to) state_nxt = S_DONE;
         S_DONE:   state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
         S_GAP:    if (cnt == GAP_LAST) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      gnt_nxt   = o_gnt;
      done_nxt  = 2'b00;
      err_nxt   = 1'b0;
      start_nxt = o_eng_start;
      rw_nxt    = o_eng_rw;
      op_nxt    = o_eng_opcode;
      rdata_nxt = o_rdata;
      g_nxt     = g;
      ptr_nxt   = ptr;
      cnt_nxt   = cnt;
      case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            if (any_req) begin
               g_nxt     = win;
               ptr_nxt   = ~win;
               gnt_nxt   = win ? 2'b10 : 2'b01;
               start_nxt = 1'b1;
               rw_nxt    = i_rw[win];
               op_nxt    = win ? i_opcode[15:8] : i_opcode[7:0];
            end
         end
         S_LAUNCH: begin
            cnt_nxt = cnt + CNT_W'(1);
            if (fin_to) begin
               start_nxt = 1'b0;
               done_nxt  = g ? 2'b10 : 2'b01;
               err_nxt   = 1'b1;
            end else if (i_eng_busy) begin
               start_nxt = 1'b0;
            end
         end
         S_WAIT: begin
            cnt_nxt = cnt + CNT_W'(1);
            if (fin_ok) begin
               rdata_nxt = i_eng_data;
               done_nxt  = g ? 2'b10 : 2'b01;
            end else if (fin_to) begin
               done_nxt  = g ? 2'b10 : 2'b01;
               err_nxt   = 1'b1;
            end
         end
         S_DONE: begin
            gnt_nxt = 2'b00;
            cnt_nxt = '0;
         end
         S_GAP:   cnt_nxt = cnt + CNT_W'(1);
         default: cnt_nxt = '0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_gnt        <= 2'b00;
         o_done       <= 2'b00;
         o_err        <= 1'b0;
         o_rdata      <= '0;
         o_eng_start  <= 1'b0;
         o_eng_rw     <= 1'b0;
         o_eng_opcode <= '0;
         g            <= 1'b0;
         ptr          <= 1'b0;
         cnt          <= '0;
      end else begin
         o_gnt        <= gnt_nxt;
         o_done       <= done_nxt;
         o_err        <= err_nxt;
         o_rdata      <= rdata_nxt;
         o_eng_start  <= start_nxt;
         o_eng_rw     <= rw_nxt;
         o_eng_opcode <= op_nxt;
         g            <= g_nxt;
         ptr          <= ptr_nxt;
         cnt          <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter with a simple engine model
// (busy a few cycles after start, tick_done ~20 cycles later, or hang).
module tb_i2c_bus_arbiter;

   localparam int BOUND = 200;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req, rw;
   logic [15:0] opcode;
   logic [1:0]  gnt, done;
   logic        err;
   logic [15:0] rdata;
   logic        eng_start, eng_rw, eng_busy, eng_tick;
   logic [7:0]  eng_op;
   logic [15:0] eng_data;
   logic        eng_hang, eng_run;
   int          eng_cnt;
   int          n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   i2c_bus_arbiter #(.TIMEOUT_CYCLES(1000), .GAP_CYCLES(4), .CNT_W(32)) dut (
      .i_clk(clk), .i_rst(rst_n), .i_req(req), .i_rw(rw), .i_opcode(opcode),
      .o_gnt(gnt), .o_done(done), .o_err(err), .o_rdata(rdata),
      .o_eng_start(eng_start), .o_eng_rw(eng_rw), .o_eng_opcode(eng_op),
      .i_eng_busy(eng_busy), .i_eng_tick_done(eng_tick), .i_eng_data(eng_data)
   );

   // Engine model: busy 3 cycles after start is seen, tick_done 20 cycles later.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eng_run <= 1'b0; eng_cnt <= 0; eng_busy <= 1'b0; eng_tick <= 1'b0;
      end else begin
         eng_tick <= 1'b0;
         if (!eng_run) begin
            if (eng_start) begin eng_run <= 1'b1; eng_cnt <= 1; end
         end else begin
            eng_cnt <= eng_cnt + 1;
            if (eng_cnt == 3) eng_busy <= 1'b1;
            if (eng_cnt == 23 && !eng_hang) begin
               eng_tick <= 1'b1; eng_busy <= 1'b0; eng_run <= 1'b0;
            end
         end
         if (|done) begin eng_run <= 1'b0; eng_busy <= 1'b0; end
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic wait_gnt();
      int c = 0;
      while (gnt == 2'b00 && c < BOUND) begin @(negedge clk); c++; end
      if (c >= BOUND) check("wait_gnt", 32'(gnt != 2'b00), 32'd1);
   endtask

   task automatic wait_done();
      int c = 0;
      while (done == 2'b00 && c < BOUND) begin @(negedge clk); c++; end
      if (c >= BOUND) check("wait_done", 32'(done != 2'b00), 32'd1);
   endtask

   task automatic wait_start_low();
      int c = 0;
      while (eng_start && c < BOUND) begin @(negedge clk); c++; end
      if (c >= BOUND) check("wait_start_low", 32'(eng_start), 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [1:0] exp_g [4];
      logic [7:0] exp_op [4];
      int idle, c, bad;
      exp_g  = '{2'b01, 2'b10, 2'b01, 2'b10};
      exp_op = '{8'hA1, 8'hB2, 8'hA1, 8'hB2};
      req = 2'b00; rw = 2'b00; opcode = 16'h0000; eng_data = 16'h0000; eng_hang = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_done_err", 32'({done, err}), 32'd0);
      check("rst_start", 32'(eng_start), 32'd0);
      check("rst_rdata", 32'(rdata), 32'd0);
      check("rst_eng_op", 32'({eng_rw, eng_op}), 32'd0);
      rst_n = 1'b1;

      // 1: single write from requester 0
      req = 2'b01; rw = 2'b00; opcode = 16'h0001;
      @(negedge clk);
      check("t1_gnt", 32'(gnt), 32'h1);
      check("t1_start", 32'(eng_start), 32'h1);
      check("t1_opcode", 32'(eng_op), 32'h01);
      check("t1_rw", 32'(eng_rw), 32'h0);
      wait_start_low();
      check("t1_busy_at_drop", 32'(eng_busy), 32'h1);
      wait_done();
      check("t1_done", 32'(done), 32'h1);
      check("t1_err", 32'(err), 32'h0);
      check("t1_gnt_in_done", 32'(gnt), 32'h1);
      req = 2'b00;
      @(negedge clk);
      check("t1_gnt_clear", 32'(gnt), 32'h0);
      check("t1_done_clear", 32'(done), 32'h0);

      // 2: both requesting, round-robin with 4-cycle gap
      do_reset();
      req = 2'b11; opcode = 16'hB2A1;
      wait_gnt();
      for (int k = 0; k < 4; k++) begin
         if (k > 0) begin
            idle = 0;
            @(negedge clk);
            while (gnt == 2'b00 && idle < 50) begin idle++; @(negedge clk); end
            check($sformatf("t2_idle%0d", k), 32'(idle), 32'd5);
         end
         check($sformatf("t2_gnt%0d", k), 32'(gnt), 32'(exp_g[k]));
         check($sformatf("t2_op%0d", k), 32'(eng_op), 32'(exp_op[k]));
         wait_done();
         check($sformatf("t2_done%0d", k), 32'(done), 32'(exp_g[k]));
         if (k == 3) req = 2'b00;
      end
      @(negedge clk);

      // 3: requester 1 read, value held through a following write
      req = 2'b10; rw = 2'b10; opcode = 16'h5C00; eng_data = 16'h1A2B;
      wait_gnt();
      check("t3_gnt", 32'(gnt), 32'h2);
      check("t3_rw", 32'(eng_rw), 32'h1);
      check("t3_op", 32'(eng_op), 32'h5C);
      wait_done();
      check("t3_done", 32'(done), 32'h2);
      check("t3_rdata", 32'(rdata), 32'h1A2B);
      req = 2'b01; rw = 2'b00; opcode = 16'h0010; eng_data = 16'h5555;
      @(negedge clk);
      wait_gnt();
      bad = 0; c = 0;
      while (done == 2'b00 && c < BOUND) begin
         if (rdata !== 16'h1A2B) bad++;
         @(negedge clk); c++;
      end
      check("t3_hold_bad", 32'(bad), 32'd0);
      check("t3_done2", 32'(done), 32'h1);
      check("t3_rdata2", 32'(rdata), 32'h5555);
      req = 2'b00;
      @(negedge clk);

      // 4: engine hangs, timeout after 1000 cycles
      eng_hang = 1'b1; req = 2'b01; eng_data = 16'hDEAD;
      wait_gnt();
      c = 0;
      while (done == 2'b00 && c < 1100) begin @(negedge clk); c++; end
      check("t4_cycles", 32'(c), 32'd1000);
      check("t4_done", 32'(done), 32'h1);
      check("t4_err", 32'(err), 32'h1);
      check("t4_rdata", 32'(rdata), 32'h5555);
      check("t4_start", 32'(eng_start), 32'h0);
      req = 2'b10; eng_hang = 1'b0;
      @(negedge clk);
      wait_gnt();
      check("t4_next_gnt", 32'(gnt), 32'h2);
      wait_done();
      check("t4_next_done", 32'({done, err}), 32'({2'b10, 1'b0}));
      req = 2'b00;
      @(negedge clk);

      // 5: asynchronous reset mid-WAIT
      req = 2'b01; opcode = 16'h4433;
      wait_gnt();
      wait_start_low();
      #2 rst_n = 1'b0;
      #1;
      check("t5_gnt", 32'(gnt), 32'h0);
      check("t5_start", 32'(eng_start), 32'h0);
      check("t5_done", 32'(done), 32'h0);
      check("t5_rdata", 32'(rdata), 32'h0);
      @(negedge clk);
      rst_n = 1'b1; req = 2'b11;
      wait_gnt();
      check("t5_first_gnt", 32'(gnt), 32'h1);

      // 6: drop request and change opcode during WAIT
      req = 2'b01;
      wait_start_low();
      req = 2'b00; opcode = 16'hFF77; rw = 2'b11;
      repeat (3) @(negedge clk);
      check("t6_op", 32'(eng_op), 32'h33);
      check("t6_rw", 32'(eng_rw), 32'h0);
      wait_done();
      check("t6_done", 32'(done), 32'h1);
      check("t6_err", 32'(err), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
